pipe_trace_unit: RTL and testbench

//  In-CPU performance and trace source for the 5-stage pipeline. Counts cycles, stalls,

---
 rtl/pipe_trace_unit.sv | 200 ++++++++++++++++++++
 tb/tb_pipe_trace_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_trace_unit
// Purpose  : Performance counter and trace source for the 5-stage pipeline.
//            Counts RUN cycles, stalls, flushes and retirements. Each retired
//            register write (rd != x0) is queued in a trace FIFO and streamed
//            out over a valid/ready port.
// Ports    : clk_i, rst_i (async, active-high), start_i, clear_i (sync clear)
//            stall_i, flush_i, retire_i, rd_addr_i, rd_data_i, pc_i
//            trace_valid_o / trace_ready_i / trace_data_o (FIFO head)
//            cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o, drop_cnt_o
//            done_o (FSM in HALT)
// Config   : TRACE_PC_EN - when defined, trace records are 69 bits
//            {pc, rd_addr, rd_data}; otherwise 37 bits {rd_addr, rd_data}.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_trace_unit #(
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic [4:0]       rd_addr_i,
    input  logic [31:0]      rd_data_i,
    input  logic [31:0]      pc_i,
    output logic             trace_valid_o,
    input  logic             trace_ready_i,
`ifdef TRACE_PC_EN
    output logic [68:0]      trace_data_o,
`else
    output logic [36:0]      trace_data_o,
`endif
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [15:0]      drop_cnt_o,
    output logic             done_o
);

`ifdef TRACE_PC_EN
    localparam int TRACE_W = 69;
`else
    localparam int TRACE_W = 37;
`endif
    localparam int AW = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] c_cnt_one    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_max_cycles = CNT_W'(MAX_CYCLES);
    localparam logic             c_halt_en    = (MAX_CYCLES != 0);
    localparam logic [AW:0]      c_ptr_one    = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_done;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]   r_retire_cnt;
    logic [15:0]        r_drop_cnt;
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [TRACE_W-1:0] r_mem [DEPTH];

    logic               w_run;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_write;
    logic               w_drop;
    logic [CNT_W-1:0]   w_cycle_next;
    logic               w_hit_max;
    logic [TRACE_W-1:0] w_entry;

`ifdef TRACE_PC_EN
    assign w_entry = {pc_i, rd_addr_i, rd_data_i};
`else
    assign w_entry = {rd_addr_i, rd_data_i};
    // pc is not recorded in the narrow build
    logic w_unused_pc;
    assign w_unused_pc = ^pc_i;
`endif

    assign w_run        = (r_state == S_RUN);
    assign w_push       = w_run && retire_i && (rd_addr_i != 5'd0);
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    // Same slot index but opposite wrap bit means the writer lapped the reader
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop        = !w_empty && trace_ready_i;
    // A pop in the same cycle frees the slot the push needs
    assign w_write      = w_push && (!w_full || w_pop);
    assign w_drop       = w_push && w_full && !w_pop;
    assign w_cycle_next = r_cycle_cnt + c_cnt_one;
    assign w_hit_max    = c_halt_en && (w_cycle_next == c_max_cycles);

    // Control FSM with registered done flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else if (clear_i) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_hit_max) begin
                        r_state <= S_HALT;
                        r_done  <= 1'b1;
                    end else if (!start_i) begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Event counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycle_cnt  <= '0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_retire_cnt <= '0;
            r_drop_cnt   <= '0;
        end else if (clear_i) begin
            r_cycle_cnt  <= '0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_retire_cnt <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_run) begin
                r_cycle_cnt <= w_cycle_next;
                // A flush squashes the stalled instruction, so it wins
                if (flush_i)
                    r_flush_cnt <= r_flush_cnt + c_cnt_one;
                else if (stall_i)
                    r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (w_push)
                r_retire_cnt <= r_retire_cnt + c_cnt_one;
            if (w_drop && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    // FIFO storage; contents are only observable through a valid head
    always_ff @(posedge clk_i) begin
        if (w_write) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
    end

    assign trace_valid_o = !w_empty;
    assign trace_data_o  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign cycle_cnt_o   = r_cycle_cnt;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;
    assign retire_cnt_o  = r_retire_cnt;
    assign drop_cnt_o    = r_drop_cnt;
    assign done_o        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pipe_trace_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_trace_unit
// Purpose  : Self-checking bench for pipe_trace_unit: reset, a directed
//            vector table, multi-cycle FIFO/halt/reset sequences and random
//            stimulus compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_trace_unit;

`ifdef TRACE_PC_EN
    localparam int TW = 69;
`else
    localparam int TW = 37;
`endif
    localparam int DEPTH      = 8;
    localparam int CNT_W      = 32;
    localparam int MAX_CYCLES = 30;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0, clear_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic          retire_i = 1'b0, trace_ready_i = 1'b0;
    logic [4:0]    rd_addr_i = '0;
    logic [31:0]   rd_data_i = '0, pc_i = '0;
    logic          trace_valid_o, done_o;
    logic [TW-1:0] trace_data_o;
    logic [CNT_W-1:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o;
    logic [15:0]   drop_cnt_o;

    pipe_trace_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .stall_i(stall_i), .flush_i(flush_i), .retire_i(retire_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .pc_i(pc_i),
        .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .trace_data_o(trace_data_o), .cycle_cnt_o(cycle_cnt_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
        .retire_cnt_o(retire_cnt_o), .drop_cnt_o(drop_cnt_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        start, clear, stall, flush, retire;
        logic [4:0]  rd;
        logic [31:0] data, pc;
        logic        ready;
    } in_t;

    typedef struct {
        in_t         in;
        logic        exp_valid;
        logic [68:0] exp_rec;
        int          exp_cycle, exp_stall, exp_flush, exp_retire, exp_drop;
        logic        exp_done;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0=idle 1=run 2=halt, FIFO as a queue of records
    int          m_mode;
    bit [31:0]   m_cycle, m_stall, m_flush, m_retire;
    int          m_drop;
    logic [68:0] m_q[$];

    function automatic in_t mkin(logic st, logic cl, logic sa, logic fl, logic re,
                                 logic [4:0] rd, logic [31:0] d, logic [31:0] pc, logic rdy);
        in_t v;
        v.start = st; v.clear = cl; v.stall = sa; v.flush = fl; v.retire = re;
        v.rd = rd; v.data = d; v.pc = pc; v.ready = rdy;
        return v;
    endfunction

    function automatic logic [TW-1:0] pack(logic [68:0] r);
        return r[TW-1:0];
    endfunction

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cycle = 0; m_stall = 0; m_flush = 0; m_retire = 0; m_drop = 0;
        m_q.delete();
    endtask

    task automatic model_step(input in_t v);
        bit popped;
        popped = (m_q.size() > 0) && v.ready;
        if (v.clear) begin
            model_reset();
            return;
        end
        if (popped) void'(m_q.pop_front());
        if (m_mode == 1) begin
            m_cycle++;
            if (v.flush) m_flush++;
            else if (v.stall) m_stall++;
            if (v.retire && v.rd != 5'd0) begin
                m_retire++;
                if (m_q.size() < DEPTH) m_q.push_back({v.pc, v.rd, v.data});
                else if (m_drop < 65535) m_drop++;
            end
            if (MAX_CYCLES != 0 && m_cycle == MAX_CYCLES) m_mode = 2;
            else if (!v.start) m_mode = 0;
        end else if (m_mode == 0 && v.start) begin
            m_mode = 1;
        end
    endtask

    task automatic compare_model();
        chk("m_valid", trace_valid_o, (m_q.size() > 0));
        if (m_q.size() > 0) chk("m_data", trace_data_o, pack(m_q[0]));
        chk("m_cycle",  cycle_cnt_o,  m_cycle);
        chk("m_stall",  stall_cnt_o,  m_stall);
        chk("m_flush",  flush_cnt_o,  m_flush);
        chk("m_retire", retire_cnt_o, m_retire);
        chk("m_drop",   drop_cnt_o,   m_drop);
        chk("m_done",   done_o,       (m_mode == 2));
    endtask

    task automatic step(input in_t v);
        start_i = v.start; clear_i = v.clear; stall_i = v.stall; flush_i = v.flush;
        retire_i = v.retire; rd_addr_i = v.rd; rd_data_i = v.data; pc_i = v.pc;
        trace_ready_i = v.ready;
        model_step(v);
        @(posedge clk_i);
        #1;
        compare_model();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},  trace_valid_o, 0);
        chk({tag, "_data"},   trace_data_o,  0);
        chk({tag, "_cycle"},  cycle_cnt_o,   0);
        chk({tag, "_stall"},  stall_cnt_o,   0);
        chk({tag, "_flush"},  flush_cnt_o,   0);
        chk({tag, "_retire"}, retire_cnt_o,  0);
        chk({tag, "_drop"},   drop_cnt_o,    0);
        chk({tag, "_done"},   done_o,        0);
    endtask

    vec_t tbl[$];

    task automatic add_row(input in_t v, input logic ev, input logic [68:0] er,
                           input int c, input int s, input int f, input int r,
                           input int d, input logic dn);
        vec_t t;
        t.in = v; t.exp_valid = ev; t.exp_rec = er; t.exp_cycle = c; t.exp_stall = s;
        t.exp_flush = f; t.exp_retire = r; t.exp_drop = d; t.exp_done = dn;
        tbl.push_back(t);
    endtask

    initial begin
        int k;
        in_t v;
        in_t idle_run;
        idle_run = mkin(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---- directed vector table ----
        add_row(mkin(0,1,0,0,0,0,0,0,0),                 0, 0, 0,0,0,0,0, 0);
        add_row(mkin(1,0,0,0,0,0,0,0,0),                 0, 0, 0,0,0,0,0, 0);
        add_row(mkin(1,0,1,0,0,0,0,0,0),                 0, 0, 1,1,0,0,0, 0);
        add_row(mkin(1,0,1,0,0,0,0,0,0),                 0, 0, 2,2,0,0,0, 0);
        add_row(mkin(1,0,1,0,0,0,0,0,0),                 0, 0, 3,3,0,0,0, 0);
        add_row(mkin(1,0,1,1,0,0,0,0,0),                 0, 0, 4,3,1,0,0, 0);
        add_row(mkin(1,0,1,1,0,0,0,0,0),                 0, 0, 5,3,2,0,0, 0);
        add_row(mkin(1,0,0,0,1,5,32'hA,32'h10,1),        1, {32'h10,5'd5,32'hA}, 6,3,2,1,0, 0);
        add_row(mkin(1,0,0,0,1,0,32'h77,32'h20,1),       0, 0, 7,3,2,1,0, 0);
        add_row(mkin(0,0,0,0,0,0,0,0,0),                 0, 0, 8,3,2,1,0, 0);
        add_row(mkin(0,0,1,0,0,0,0,0,0),                 0, 0, 8,3,2,1,0, 0);
        add_row(mkin(1,0,0,0,0,0,0,0,0),                 0, 0, 8,3,2,1,0, 0);
        add_row(mkin(1,0,0,1,0,0,0,0,0),                 0, 0, 9,3,3,1,0, 0);
        add_row(mkin(0,1,0,0,0,0,0,0,0),                 0, 0, 0,0,0,0,0, 0);

        // ---- reset state ----
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        rst_i = 1'b0;

        // ---- run to auto-halt ----
        step(idle_run);
        k = 0;
        while (!done_o && k < 40) begin
            step(idle_run);
            k++;
        end
        chk("halt_cycle",  cycle_cnt_o,  30);
        chk("halt_done",   done_o,       1);
        chk("halt_stall",  stall_cnt_o,  0);
        chk("halt_flush",  flush_cnt_o,  0);
        chk("halt_retire", retire_cnt_o, 0);
        repeat (3) step(mkin(1, 0, 1, 1, 1, 3, 1, 1, 0));
        chk("halt_frozen_cycle",  cycle_cnt_o,  30);
        chk("halt_frozen_retire", retire_cnt_o, 0);
        step(mkin(0, 1, 0, 0, 0, 0, 0, 0, 0));
        chk("clear_done", done_o, 0);

        // ---- table ----
        foreach (tbl[i]) begin
            step(tbl[i].in);
            chk($sformatf("tbl%0d_valid", i),  trace_valid_o, tbl[i].exp_valid);
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_data", i), trace_data_o, pack(tbl[i].exp_rec));
            chk($sformatf("tbl%0d_cycle", i),  cycle_cnt_o,  tbl[i].exp_cycle);
            chk($sformatf("tbl%0d_stall", i),  stall_cnt_o,  tbl[i].exp_stall);
            chk($sformatf("tbl%0d_flush", i),  flush_cnt_o,  tbl[i].exp_flush);
            chk($sformatf("tbl%0d_retire", i), retire_cnt_o, tbl[i].exp_retire);
            chk($sformatf("tbl%0d_drop", i),   drop_cnt_o,   tbl[i].exp_drop);
            chk($sformatf("tbl%0d_done", i),   done_o,       tbl[i].exp_done);
        end

        // ---- overflow: 10 retirements into 8 entries, then drain ----
        step(mkin(0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(idle_run);
        for (int i = 0; i < 10; i++)
            step(mkin(1, 0, 0, 0, 1, 5'(i + 1), 32'(100 + i), 32'(4 * i), 0));
        chk("ovf_retire", retire_cnt_o, 10);
        chk("ovf_drop",   drop_cnt_o,   2);
        chk("ovf_valid",  trace_valid_o, 1);
        step(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0));
        k = 0;
        while (trace_valid_o && k < 12) begin
            chk($sformatf("drain%0d_data", k), trace_data_o,
                pack({32'(4 * k), 5'(k + 1), 32'(100 + k)}));
            step(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1));
            k++;
        end
        chk("drain_count", k, 8);
        chk("drain_valid_low", trace_valid_o, 0);

        // ---- full FIFO with simultaneous push and pop ----
        step(mkin(0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(idle_run);
        for (int i = 0; i < 8; i++)
            step(mkin(1, 0, 0, 0, 1, 5'(i + 1), 32'(i), 32'(i), 0));
        step(mkin(1, 0, 0, 0, 1, 5'd9, 32'h99, 32'h99, 1));
        chk("fullpp_drop",   drop_cnt_o,   0);
        chk("fullpp_retire", retire_cnt_o, 9);
        step(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0));
        k = 0;
        while (trace_valid_o && k < 12) begin
            step(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1));
            k++;
        end
        chk("fullpp_occupancy", k, 8);

        // ---- randomized against the model ----
        step(mkin(0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int blk = 0; blk < 12; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(0, 100);
            for (int i = 0; i < 50; i++) begin
                v.start  = ($urandom_range(0, 9) != 0);
                v.clear  = ($urandom_range(0, 39) == 0);
                v.stall  = $urandom_range(0, 1);
                v.flush  = ($urandom_range(0, 3) == 0);
                v.retire = ($urandom_range(0, 2) != 0);
                v.rd     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
                v.data   = $urandom;
                v.pc     = $urandom;
                v.ready  = ($urandom_range(0, 99) < rdy_pct);
                step(v);
            end
        end

        // ---- asynchronous reset with records queued ----
        step(mkin(0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(idle_run);
        for (int i = 0; i < 3; i++)
            step(mkin(1, 0, 1, 0, 1, 5'(i + 7), 32'(i), 32'(i), 0));
        chk("prerst_valid", trace_valid_o, 1);
        #3;
        rst_i = 1'b1;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("postrst_valid", trace_valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
